// File: rtl/frequency_meter_if.sv
// Signal bundle for the frequency meter: the measured input, the run
// control and the measurement results. clk and reset stay plain ports.
interface frequency_meter_if #(
  parameter int COUNT_WIDTH  = 32,
  parameter int PERIOD_WIDTH = 32
);
  logic                    sigIn;
  logic                    enable;
  logic [COUNT_WIDTH-1:0]  freqCount;
  logic [PERIOD_WIDTH-1:0] periodCycles;
  logic                    valid;
  logic                    overflow;
  logic                    noSignal;

  // Side that supplies the signal and enable and consumes the results.
  modport master (
    output sigIn,
    output enable,
    input  freqCount,
    input  periodCycles,
    input  valid,
    input  overflow,
    input  noSignal
  );

  // The meter itself.
  modport slave (
    input  sigIn,
    input  enable,
    output freqCount,
    output periodCycles,
    output valid,
    output overflow,
    output noSignal
  );
endinterface

// File: rtl/frequency_meter.sv
// Frequency / period meter for a slow asynchronous square wave.
// Rising edges of sigIn are counted over back-to-back gate windows of
// GATE_CYCLES clk cycles, and the clk-cycle spacing of the last two
// rising edges is reported as the period.
module frequency_meter #(
  parameter int GATE_CYCLES  = 50000000,
  parameter int COUNT_WIDTH  = 32,
  parameter int PERIOD_WIDTH = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clk,
  input  logic         reset,
  frequency_meter_if.slave bus
);

  localparam int TIMER_WIDTH = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] GATE_LAST = TIMER_WIDTH'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  // Synchronizer and edge history.
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    hist_q, hist_d;
  logic                    rise;

  // Measurement state.
  state_e                  state_q, state_d;
  logic [TIMER_WIDTH-1:0]  gate_timer_q, gate_timer_d;
  logic [COUNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic                    ovf_q, ovf_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    have_prev_q, have_prev_d;

  // Registered results.
  logic [COUNT_WIDTH-1:0]  freq_count_q, freq_count_d;
  logic [PERIOD_WIDTH-1:0] period_cycles_q, period_cycles_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    no_signal_q, no_signal_d;

  logic                    window_end;
  logic                    edge_full;
  logic                    period_full;

  // Shift sigIn through the synchronizer; history holds the previous output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.sigIn};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  assign rise        = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign window_end  = (gate_timer_q == GATE_LAST);
  assign edge_full   = &edge_cnt_q;
  assign period_full = &period_cnt_q;

  // Next-state logic for the gate window, edge counter and period counter.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned
    // and no latch is inferred; the default is "hold", valid defaults low.
    state_d         = state_q;
    gate_timer_d    = gate_timer_q;
    edge_cnt_d      = edge_cnt_q;
    ovf_d           = ovf_q;
    period_cnt_d    = period_cnt_q;
    have_prev_d     = have_prev_q;
    freq_count_d    = freq_count_q;
    period_cycles_d = period_cycles_q;
    valid_d         = 1'b0;
    overflow_d      = overflow_q;
    no_signal_d     = no_signal_q;

    unique case (state_q)
      IDLE: begin
        gate_timer_d = '0;
        edge_cnt_d   = '0;
        ovf_d        = 1'b0;
        period_cnt_d = '0;
        have_prev_d  = 1'b0;
        if (bus.enable) begin
          state_d = GATE;
        end
      end

      GATE: begin
        // Gate window: a rise in the final cycle belongs to this window.
        if (window_end) begin
          freq_count_d = (rise && !edge_full) ? edge_cnt_q + COUNT_WIDTH'(1)
                                              : edge_cnt_q;
          overflow_d   = ovf_q | (rise & edge_full);
          valid_d      = 1'b1;
          gate_timer_d = '0;
          edge_cnt_d   = '0;
          ovf_d        = 1'b0;
        end else begin
          gate_timer_d = gate_timer_q + TIMER_WIDTH'(1);
          if (rise) begin
            if (edge_full) begin
              ovf_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
            end
          end
        end

        // Dropping enable discards a partial window but still lets the
        // window-end cycle report.
        if (!bus.enable) begin
          state_d = IDLE;
        end

        // Period: restart the counter at 1 on each rise so that two rises
        // delta cycles apart report exactly delta.
        if (rise) begin
          period_cnt_d = PERIOD_WIDTH'(1);
          if (have_prev_q) begin
            period_cycles_d = period_cnt_q;
            no_signal_d     = 1'b0;
          end else begin
            have_prev_d = 1'b1;
          end
        end else if (period_full) begin
          no_signal_d = 1'b1;
        end else begin
          period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q          <= '0;
      hist_q          <= 1'b0;
      state_q         <= IDLE;
      gate_timer_q    <= '0;
      edge_cnt_q      <= '0;
      ovf_q           <= 1'b0;
      period_cnt_q    <= '0;
      have_prev_q     <= 1'b0;
      freq_count_q    <= '0;
      period_cycles_q <= '0;
      valid_q         <= 1'b0;
      overflow_q      <= 1'b0;
      no_signal_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      sync_q          <= sync_d;
      hist_q          <= hist_d;
      state_q         <= state_d;
      gate_timer_q    <= gate_timer_d;
      edge_cnt_q      <= edge_cnt_d;
      ovf_q           <= ovf_d;
      period_cnt_q    <= period_cnt_d;
      have_prev_q     <= have_prev_d;
      freq_count_q    <= freq_count_d;
      period_cycles_q <= period_cycles_d;
      valid_q         <= valid_d;
      overflow_q      <= overflow_d;
      no_signal_q     <= no_signal_d;
    end
  end

  assign bus.freqCount    = freq_count_q;
  assign bus.periodCycles = period_cycles_q;
  assign bus.valid        = valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.noSignal     = no_signal_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter. Two instances with GATE_CYCLES=100: a wide
// one (32/32) and a narrow one (COUNT_WIDTH=3, PERIOD_WIDTH=4). Stimulus
// pushes expected window results into per-instance queues; monitors pop
// and compare on every valid pulse.
module tb_frequency_meter;

  localparam int GATE = 100;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clk = ~clk;

  frequency_meter_if #(.COUNT_WIDTH(32), .PERIOD_WIDTH(32)) if_a ();
  frequency_meter_if #(.COUNT_WIDTH(3),  .PERIOD_WIDTH(4))  if_b ();

  frequency_meter #(
    .GATE_CYCLES (GATE),
    .COUNT_WIDTH (32),
    .PERIOD_WIDTH(32),
    .SYNC_STAGES (2)
  ) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bus  (if_a)
  );

  frequency_meter #(
    .GATE_CYCLES (GATE),
    .COUNT_WIDTH (3),
    .PERIOD_WIDTH(4),
    .SYNC_STAGES (2)
  ) dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (if_b)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vcnt_a = 0, vcnt_b = 0;
  int   vcyc_a = 0, vcyc_b = 0;
  int   sum_a  = 0;

  // Waveform generators: per=0 means follow man_x, else period per, high hi.
  int   per_a = 0, hi_a = 0, ph_a = 0;
  int   per_b = 0, hi_b = 0, ph_b = 0;
  logic man_a = 1'b0, man_b = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (per_a == 0) begin
      if_a.sigIn = man_a;
      ph_a = 0;
    end else begin
      if_a.sigIn = (ph_a < hi_a);
      ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
    end
  end

  always @(negedge clk) begin
    if (per_b == 0) begin
      if_b.sigIn = man_b;
      ph_b = 0;
    end else begin
      if_b.sigIn = (ph_b < hi_b);
      ph_b = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Monitors: compare each reported window against the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_a.valid === 1'b1) begin
      vcnt_a++;
      vcyc_a = cyc;
      sum_a += int'(if_a.freqCount);
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_a: got freqCount=%0d, expected no valid (cycle %0d)",
                 if_a.freqCount, cyc);
      end else begin
        e = q_a.pop_front();
        check_range("freq_a", longint'(if_a.freqCount), e.lo, e.hi);
        check("overflow_a", if_a.overflow, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_b.valid === 1'b1) begin
      vcnt_b++;
      vcyc_b = cyc;
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid_b: got freqCount=%0d, expected no valid (cycle %0d)",
                 if_b.freqCount, cyc);
      end else begin
        e = q_b.pop_front();
        check_range("freq_b", longint'(if_b.freqCount), e.lo, e.hi);
        check("overflow_b", if_b.overflow, e.ovf);
      end
    end
  end

  // Stimulus acts 2 time units after each rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_valid(input bit sel, input int target, input int budget);
    int k = 0;
    while (((sel ? vcnt_b : vcnt_a) < target) && k < budget) begin
      tick();
      k++;
    end
    if ((sel ? vcnt_b : vcnt_a) < target) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout_%s: got %0d valids, expected %0d",
               sel ? "b" : "a", sel ? vcnt_b : vcnt_a, target);
    end
  endtask

  task automatic push_a(input int lo, input int hi, input bit ovf);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int lo, input int hi, input bit ovf);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    q_b.push_back(e);
  endtask

  initial begin
    int e_cyc;
    int v;
    int n0;
    int t;

    reset_a = 1'b1;
    reset_b = 1'b1;
    if_a.enable = 1'b0;
    if_b.enable = 1'b0;
    per_a = 10; hi_a = 5;
    per_b = 4;  hi_b = 2;
    tick(3);

    // Reset state.
    check("rst_freq_a",     if_a.freqCount,    0);
    check("rst_period_a",   if_a.periodCycles, 0);
    check("rst_valid_a",    if_a.valid,        0);
    check("rst_overflow_a", if_a.overflow,     0);
    check("rst_nosig_a",    if_a.noSignal,     0);
    check("rst_freq_b",     if_b.freqCount,    0);
    check("rst_period_b",   if_b.periodCycles, 0);
    check("rst_nosig_b",    if_b.noSignal,     0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick(20);

    // Period-10 square wave: 10 edges per window.
    repeat (3) push_a(10, 10, 1'b0);
    if_a.enable = 1'b1;
    e_cyc = cyc + 1;
    wait_valid(1'b0, 1, 300);
    check("first_latency_a", vcyc_a - e_cyc, GATE);
    wait_valid(1'b0, 3, 300);
    check("period10_a", if_a.periodCycles, 10);
    check("nosig10_a",  if_a.noSignal,     0);

    // Abort with gateTimer at 50, idle 20 cycles, re-enter.
    v = vcyc_a;
    tick_until(v + 50);
    if_a.enable = 1'b0;
    per_a = 0;
    man_a = 1'b0;
    n0 = vcnt_a;
    tick(20);
    check("abort_no_valid_a", vcnt_a,         n0);
    check("abort_hold_freq_a", if_a.freqCount, 10);
    if_a.enable = 1'b1;
    e_cyc = cyc + 1;
    tick(2);
    per_a = 12; hi_a = 6;
    // Rises land at window cycles 4,16,...,100: 9 edges, the last in the final cycle.
    push_a(9, 9, 1'b0);
    tick_until(e_cyc + 10);
    check("period_one_edge_a", if_a.periodCycles, 10);
    tick_until(e_cyc + 20);
    check("period_two_edges_a", if_a.periodCycles, 12);
    wait_valid(1'b0, n0 + 1, 300);
    check("reentry_latency_a", vcyc_a - e_cyc, GATE);

    // enable low on the window-end cycle: window still reports (8 edges), then idle.
    push_a(8, 8, 1'b0);
    v = vcyc_a;
    tick_until(v + 99);
    if_a.enable = 1'b0;
    wait_valid(1'b0, n0 + 2, 50);
    tick(150);
    check("idle_no_valid_a", vcnt_a, n0 + 2);

    // Period-7 wave: 14 or 15 per window, 100 over 7 windows.
    per_a = 7; hi_a = 3;
    tick(20);
    repeat (7) push_a(14, 15, 1'b0);
    sum_a = 0;
    if_a.enable = 1'b1;
    wait_valid(1'b0, n0 + 9, 1000);
    check("sum7_a",    sum_a,             100);
    check("period7_a", if_a.periodCycles, 7);

    // Asynchronous reset mid-window.
    v = vcyc_a;
    tick_until(v + 40);
    reset_a = 1'b1;
    #1;
    check("async_rst_freq_a",   if_a.freqCount,    0);
    check("async_rst_period_a", if_a.periodCycles, 0);
    check("async_rst_ovf_a",    if_a.overflow,     0);
    check("async_rst_nosig_a",  if_a.noSignal,     0);
    check("async_rst_valid_a",  if_a.valid,        0);
    tick(3);
    reset_a = 1'b0;
    e_cyc = cyc + 1;
    push_a(14, 16, 1'b0);
    wait_valid(1'b0, n0 + 10, 300);
    check("post_rst_latency_a", vcyc_a - e_cyc, GATE);
    if_a.enable = 1'b0;

    // Narrow counter: period 4 gives 25 edges, saturates at 7.
    push_b(7, 7, 1'b1);
    push_b(7, 7, 1'b1);
    if_b.enable = 1'b1;
    wait_valid(1'b1, 2, 300);
    if_b.enable = 1'b0;
    per_b = 20; hi_b = 10;
    tick(25);
    push_b(5, 5, 1'b0);
    if_b.enable = 1'b1;
    wait_valid(1'b1, 3, 300);

    // Narrow period counter: period-5 pair, then silence, then one edge.
    if_b.enable = 1'b0;
    per_b = 0;
    man_b = 1'b0;
    tick(10);
    if_b.enable = 1'b1;
    tick(2);
    t = cyc;
    man_b = 1'b1;
    tick_until(t + 2);  man_b = 1'b0;
    tick_until(t + 5);  man_b = 1'b1;
    tick_until(t + 7);  man_b = 1'b0;
    tick_until(t + 10);
    check("period5_b",       if_b.periodCycles, 5);
    check("nosig_clear5_b",  if_b.noSignal,     0);
    tick_until(t + 22);
    check("nosig_before_b",  if_b.noSignal,     0);
    tick_until(t + 23);
    check("nosig_set_b",     if_b.noSignal,     1);
    check("period_hold_b",   if_b.periodCycles, 5);
    tick_until(t + 30); man_b = 1'b1;
    tick_until(t + 32); man_b = 1'b0;
    tick_until(t + 36);
    check("period_sat_b",    if_b.periodCycles, 15);
    check("nosig_cleared_b", if_b.noSignal,     0);
    if_b.enable = 1'b0;

    tick(20);
    check("queue_empty_a", q_a.size(), 0);
    check("queue_empty_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
